// File: rtl/bf16_mul_pipe_pkg.sv
// bf16_mul_pipe_pkg: shared bfloat16 constants, field widths and special-case codes
package bf16_mul_pipe_pkg;
  localparam int BF16_EXP_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_POS_INF = 16'h7F80;
  localparam logic [15:0] BF16_NEG_INF = 16'hFF80;
  typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_e;
endpackage

// File: rtl/bf16_class.sv
// bf16_class: per-operand bfloat16 classifier; sub_norm_o covers zero as well as subnormals
module bf16_class
  import bf16_mul_pipe_pkg::*;
(
  input  logic [15:0] a_i,
  output logic        inf_o,
  output logic        neg_inf_o,
  output logic        nan_o,
  output logic        sub_norm_o,
  output logic        normal_o
);
  logic [EXP_W-1:0] e;
  logic m_zero;
  assign e = a_i[MAN_W +: EXP_W];
  assign m_zero = a_i[MAN_W-1:0] == '0;
  assign nan_o = &e & ~m_zero;
  assign inf_o = &e & m_zero & ~a_i[15];
  assign neg_inf_o = &e & m_zero & a_i[15];
  assign sub_norm_o = e == '0;
  assign normal_o = ~&e & |e;
endmodule

// File: rtl/bf16_round_pack.sv
// bf16_round_pack: rounds a normalized 8-bit significand, packs bfloat16 and raises flags
module bf16_round_pack
  import bf16_mul_pipe_pkg::*;
#(
  parameter bit          ROUND_RNE = 1'b1,
  parameter logic [15:0] CANON_NAN = BF16_QNAN
) (
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [7:0]        mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  spc_e              spc_i,
  output logic [15:0]       result_o,
  output logic              invalid_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              inexact_o
);
  logic inc, spc, ovf, unf;
  logic [8:0] sum;
  logic [6:0] mant;
  logic signed [9:0] exp;
  assign inc = ROUND_RNE & guard_i & (sticky_i | mant_i[0]);
  assign sum = {1'b0, mant_i} + 9'(inc);
  assign mant = sum[8] ? sum[7:1] : sum[6:0];
  assign exp = exp_i + 10'(sum[8]);
  assign spc = spc_i != SPC_NONE;
  assign ovf = ~spc & (exp >= 10'sd255);
  assign unf = ~spc & (exp <= 10'sd0);
  assign result_o = (spc_i == SPC_NAN) ? CANON_NAN
                  : (spc_i == SPC_INF || ovf) ? (sign_i ? BF16_NEG_INF : BF16_POS_INF)
                  : (spc_i == SPC_ZERO || unf) ? {sign_i, 15'h0}
                  : {sign_i, exp[7:0], mant};
  assign invalid_o = spc_i == SPC_NAN;
  assign overflow_o = ovf;
  assign underflow_o = unf;
  assign inexact_o = ~spc & (ovf | unf | guard_i | sticky_i);
endmodule

// File: rtl/bf16_mul_pipe.sv
// bf16_mul_pipe: three-stage valid/ready bfloat16 multiplier (classify, multiply, round/pack)
module bf16_mul_pipe
  import bf16_mul_pipe_pkg::*;
#(
  parameter bit          ROUND_RNE = 1'b1,
  parameter logic [15:0] CANON_NAN = BF16_QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Result,
  output logic        Invalid,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Inexact
);
  logic a_inf, a_ninf, a_nan, a_sub, a_norm;
  logic b_inf, b_ninf, b_nan, b_sub, b_norm;
  logic s1_adv, s2_adv, s3_adv;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_sign_q, s2_sign_q;
  spc_e s1_spc_d, s1_spc_q, s2_spc_q;
  logic signed [9:0] s1_exp_d, s1_exp_q, s2_exp_d, s2_exp_q;
  logic [7:0] s1_ma_q, s1_mb_q, s2_mant_d, s2_mant_q;
  logic s2_g_d, s2_g_q, s2_s_d, s2_s_q;
  logic [15:0] p, rp_res, res_q;
  logic rp_inv, rp_ovf, rp_unf, rp_inx;
  logic inv_q, ovf_q, unf_q, inx_q;
  bf16_class u_cls_a (.a_i(A), .inf_o(a_inf), .neg_inf_o(a_ninf), .nan_o(a_nan), .sub_norm_o(a_sub), .normal_o(a_norm));
  bf16_class u_cls_b (.a_i(B), .inf_o(b_inf), .neg_inf_o(b_ninf), .nan_o(b_nan), .sub_norm_o(b_sub), .normal_o(b_norm));
  assign s3_adv = ~s3_valid_q | out_ready;
  assign s2_adv = ~s2_valid_q | s3_adv;
  assign s1_adv = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign s1_spc_d = (a_nan | b_nan) ? SPC_NAN
                  : (a_inf | a_ninf | b_inf | b_ninf) ? ((a_sub | b_sub) ? SPC_NAN : SPC_INF)
                  : (a_norm & b_norm) ? SPC_NONE : SPC_ZERO;
  assign s1_exp_d = 10'(A[MAN_W +: EXP_W]) + 10'(B[MAN_W +: EXP_W]) - 10'(BF16_EXP_BIAS);
  always_ff @(posedge clk) begin
    if (rst) s1_valid_q <= 1'b0;
    else if (s1_adv) begin
      s1_valid_q <= in_valid;
      s1_sign_q <= A[15] ^ B[15];
      s1_spc_q <= s1_spc_d;
      s1_exp_q <= s1_exp_d;
      s1_ma_q <= {1'b1, A[MAN_W-1:0]};
      s1_mb_q <= {1'b1, B[MAN_W-1:0]};
    end
  end
  assign p = s1_ma_q * s1_mb_q;
  assign s2_exp_d = s1_exp_q + 10'(p[15]);
  assign s2_mant_d = p[15] ? p[15:8] : p[14:7];
  assign s2_g_d = p[15] ? p[7] : p[6];
  assign s2_s_d = p[15] ? |p[6:0] : |p[5:0];
  always_ff @(posedge clk) begin
    if (rst) s2_valid_q <= 1'b0;
    else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q <= s1_sign_q;
      s2_spc_q <= s1_spc_q;
      s2_exp_q <= s2_exp_d;
      s2_mant_q <= s2_mant_d;
      s2_g_q <= s2_g_d;
      s2_s_q <= s2_s_d;
    end
  end
  bf16_round_pack #(.ROUND_RNE(ROUND_RNE), .CANON_NAN(CANON_NAN)) u_rp (
    .sign_i(s2_sign_q), .exp_i(s2_exp_q), .mant_i(s2_mant_q), .guard_i(s2_g_q),
    .sticky_i(s2_s_q), .spc_i(s2_spc_q), .result_o(rp_res), .invalid_o(rp_inv),
    .overflow_o(rp_ovf), .underflow_o(rp_unf), .inexact_o(rp_inx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      res_q <= 16'h0000;
      {inv_q, ovf_q, unf_q, inx_q} <= 4'b0000;
    end else if (s3_adv) begin
      s3_valid_q <= s2_valid_q;
      res_q <= rp_res;
      {inv_q, ovf_q, unf_q, inx_q} <= {rp_inv, rp_ovf, rp_unf, rp_inx};
    end
  end
  assign out_valid = s3_valid_q;
  assign Result = res_q;
  assign Invalid = inv_q;
  assign Overflow = ovf_q;
  assign Underflow = unf_q;
  assign Inexact = inx_q;
endmodule

// File: tb/tb_bf16_mul_pipe.sv
// tb_bf16_mul_pipe: table-driven scoreboard bench for the pipelined bfloat16 multiplier
module tb_bf16_mul_pipe;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, Result;
  logic Invalid, Overflow, Underflow, Inexact;
  int errors = 0;
  int checks = 0;
  int acc;
  vec_t vt[20];
  vec_t sb[$];
  bf16_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Invalid(Invalid),
    .Overflow(Overflow), .Underflow(Underflow), .Inexact(Inexact)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  task automatic send(input vec_t v);
    int n = 0;
    in_valid = 1'b1;
    A = v.a;
    B = v.b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 16'(in_ready), 16'd1);
    else sb.push_back(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 16'(sb.size()), 16'd0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out", 16'(out_valid), 16'd0);
      else if (out_ready) begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("res %h*%h", e.a, e.b), Result, e.res);
        chk($sformatf("flags %h*%h", e.a, e.b), 16'({Invalid, Overflow, Underflow, Inexact}), 16'(e.flg));
      end else chk("stall_hold", Result, sb[0].res);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{16'h3FC0, 16'h4000, 16'h4040, 4'b0000};
    vt[1]  = '{16'h3F81, 16'h3F81, 16'h3F82, 4'b0001};
    vt[2]  = '{16'h7F00, 16'h4000, 16'h7F80, 4'b0101};
    vt[3]  = '{16'h7F80, 16'h0000, 16'h7FC0, 4'b1000};
    vt[4]  = '{16'hFF80, 16'h4000, 16'hFF80, 4'b0000};
    vt[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000};
    vt[6]  = '{16'h0080, 16'h3F00, 16'h0000, 4'b0011};
    vt[7]  = '{16'h8001, 16'h3F80, 16'h8000, 4'b0000};
    vt[8]  = '{16'h3FC1, 16'h3FC1, 16'h4012, 4'b0001};
    vt[9]  = '{16'h3F88, 16'h3FA8, 16'h3FB2, 4'b0001};
    vt[10] = '{16'h3F88, 16'h3F98, 16'h3FA2, 4'b0001};
    vt[11] = '{16'h3F97, 16'h3FD9, 16'h4000, 4'b0001};
    vt[12] = '{16'hBFC0, 16'h4000, 16'hC040, 4'b0000};
    vt[13] = '{16'h8080, 16'h0080, 16'h8000, 4'b0011};
    vt[14] = '{16'h0080, 16'h3F80, 16'h0080, 4'b0000};
    vt[15] = '{16'h0000, 16'hC000, 16'h8000, 4'b0000};
    vt[16] = '{16'hFF80, 16'hFF80, 16'h7F80, 4'b0000};
    vt[17] = '{16'h7FC1, 16'h7F80, 16'h7FC0, 4'b1000};
    vt[18] = '{16'h0001, 16'h7F80, 16'h7FC0, 4'b1000};
    vt[19] = '{16'h7F7F, 16'h3F80, 16'h7F7F, 4'b0000};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_result", Result, 16'h0000);
    chk("rst_flags", 16'({Invalid, Overflow, Underflow, Inexact}), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    send(vt[0]);
    @(negedge clk);
    chk("lat_c1", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("lat_c2", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("lat_c3", 16'(out_valid), 16'd1);
    @(posedge clk);
    #1;
    drain();
    for (int i = 0; i < 20; i++) send(vt[i]);
    drain();
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(vt[i + 8]);
      begin
        acc = 0;
        repeat (5) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
        end
        chk("bp_accepts", 16'(acc), 16'd3);
        chk("bp_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vt[i + 1]);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_in_ready", 16'(in_ready), 16'd1);
    chk("midrst_result", Result, 16'h0000);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", 16'(out_valid), 16'd0);
    end
    @(posedge clk);
    #1;
    send(vt[12]);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
